color_bbox_multi: RTL

Parametrised multi-channel bounding-box detector for the video pipeline. It sits after the colour-space or threshold stage. It takes one pixel per valid cycle plus a start-of-frame marker and tracks N_CH independent masked colour keys. For each key it reports the bounding box and pixel count of every matching pixel in the frame. All outputs are frame-latched, and a one-cycle `bbox_valid` pulse marks each update.

---
 rtl/color_bbox_multi.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/color_bbox_multi.sv
// color_bbox_multi: per-channel masked colour-key bounding-box detector.
// It tracks N_CH keys over a raster frame of IMG_W x IMG_H pixels.
// At the last pixel it latches each channel's box and count, then pulses bbox_valid.
// An sof arriving mid-frame aborts the frame, pulses frame_err and restarts at (0,0).
module color_bbox_multi #(
   parameter int IMG_W   = 1024,
   parameter int IMG_H   = 768,
   parameter int DW      = 16,
   parameter int N_CH    = 2,
   parameter int CW      = 11,
   parameter int CNT_W   = 20,
   parameter int MIN_PIX = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DW-1:0]         pix_data,
   input  logic                  pix_valid,
   input  logic                  sof,
   input  logic [N_CH*DW-1:0]    key,
   input  logic [N_CH*DW-1:0]    mask,
   output logic [N_CH*CW-1:0]    x_min,
   output logic [N_CH*CW-1:0]    x_max,
   output logic [N_CH*CW-1:0]    y_min,
   output logic [N_CH*CW-1:0]    y_max,
   output logic [N_CH*CNT_W-1:0] pix_cnt,
   output logic [N_CH-1:0]       found,
   output logic                  bbox_valid,
   output logic                  frame_err
);

   localparam logic [CW-1:0]    X_LAST = CW'(IMG_W - 1);
   localparam logic [CW-1:0]    Y_LAST = CW'(IMG_H - 1);
   localparam logic [CNT_W-1:0] MIN_C  = CNT_W'(MIN_PIX);

   typedef enum logic {
      WAIT_SOF,
      ACTIVE
   } state_t;

   state_t state, state_next;

   logic [CW-1:0] cnt_x, cnt_y;
   logic [CW-1:0] cur_x, cur_y;
   logic          accept, last, early;

   logic [CW-1:0]    xmn [N_CH];
   logic [CW-1:0]    xmx [N_CH];
   logic [CW-1:0]    ymn [N_CH];
   logic [CW-1:0]    ymx [N_CH];
   logic [CNT_W-1:0] cnt [N_CH];

   logic [CW-1:0]    m_xmn [N_CH];
   logic [CW-1:0]    m_xmx [N_CH];
   logic [CW-1:0]    m_ymn [N_CH];
   logic [CW-1:0]    m_ymx [N_CH];
   logic [CNT_W-1:0] m_cnt [N_CH];
   logic [N_CH-1:0]  hit;
   logic [N_CH-1:0]  m_found;

   // Pixel acceptance, effective position (sof forces 0,0), last-pixel and early-sof detection
   always_comb begin
      accept = pix_valid & ((state == ACTIVE) | sof);
      cur_x  = sof ? '0 : cnt_x;
      cur_y  = sof ? '0 : cnt_y;
      last   = accept && (cur_x == X_LAST) && (cur_y == Y_LAST);
      early  = pix_valid & sof & (state == ACTIVE);
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= WAIT_SOF;
      else        state <= state_next;
   end

   // FSM next state: any accepted pixel keeps the frame active until the last one
   always_comb begin
      state_next = state;
      if (accept) state_next = last ? WAIT_SOF : ACTIVE;
   end

   // Raster position counters, advanced only on accepted pixels
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_x <= '0;
         cnt_y <= '0;
      end else if (accept) begin
         if (last) begin
            cnt_x <= '0;
            cnt_y <= '0;
         end else if (cur_x == X_LAST) begin
            cnt_x <= '0;
            cnt_y <= cur_y + CW'(1);
         end else begin
            cnt_x <= cur_x + CW'(1);
            cnt_y <= cur_y;
         end
      end
   end

   // Per-channel match and merge of the current pixel into the accumulators
   // (an sof pixel merges into a fresh accumulator, discarding any aborted frame)
   always_comb begin
      for (int unsigned i = 0; i < N_CH; i++) begin
         hit[i] = ((pix_data & mask[i*DW +: DW]) == (key[i*DW +: DW] & mask[i*DW +: DW]));
         if (sof) begin
            m_xmn[i] = X_LAST;
            m_xmx[i] = '0;
            m_ymn[i] = Y_LAST;
            m_ymx[i] = '0;
            m_cnt[i] = '0;
         end else begin
            m_xmn[i] = xmn[i];
            m_xmx[i] = xmx[i];
            m_ymn[i] = ymn[i];
            m_ymx[i] = ymx[i];
            m_cnt[i] = cnt[i];
         end
         if (hit[i]) begin
            if (cur_x < m_xmn[i]) m_xmn[i] = cur_x;
            if (cur_x > m_xmx[i]) m_xmx[i] = cur_x;
            if (cur_y < m_ymn[i]) m_ymn[i] = cur_y;
            if (cur_y > m_ymx[i]) m_ymx[i] = cur_y;
            if (m_cnt[i] != '1)   m_cnt[i] = m_cnt[i] + CNT_W'(1);
         end
         m_found[i] = (m_cnt[i] >= MIN_C);
      end
   end

   // Accumulator registers: re-initialised at reset and after the last pixel
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < N_CH; i++) begin
            xmn[i] <= X_LAST;
            xmx[i] <= '0;
            ymn[i] <= Y_LAST;
            ymx[i] <= '0;
            cnt[i] <= '0;
         end
      end else if (accept) begin
         for (int unsigned i = 0; i < N_CH; i++) begin
            if (last) begin
               xmn[i] <= X_LAST;
               xmx[i] <= '0;
               ymn[i] <= Y_LAST;
               ymx[i] <= '0;
               cnt[i] <= '0;
            end else begin
               xmn[i] <= m_xmn[i];
               xmx[i] <= m_xmx[i];
               ymn[i] <= m_ymn[i];
               ymx[i] <= m_ymx[i];
               cnt[i] <= m_cnt[i];
            end
         end
      end
   end

   // Frame-latched results and the one-cycle status pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_min      <= '0;
         x_max      <= '0;
         y_min      <= '0;
         y_max      <= '0;
         pix_cnt    <= '0;
         found      <= '0;
         bbox_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         bbox_valid <= last;
         frame_err  <= early;
         if (last) begin
            for (int unsigned i = 0; i < N_CH; i++) begin
               found[i]                  <= m_found[i];
               pix_cnt[i*CNT_W +: CNT_W] <= m_cnt[i];
               x_min[i*CW +: CW]         <= m_found[i] ? m_xmn[i] : '0;
               x_max[i*CW +: CW]         <= m_found[i] ? m_xmx[i] : '0;
               y_min[i*CW +: CW]         <= m_found[i] ? m_ymn[i] : '0;
               y_max[i*CW +: CW]         <= m_found[i] ? m_ymx[i] : '0;
            end
         end
      end
   end

endmodule
